// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD-read / 2-write register file with post-reset scrub.
// Optional same-cycle write-to-read bypass when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    output logic                     busy,
    output logic                     wr_drop
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {SCRUB, RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   ptr, ptr_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok, acc0, acc1;

    // state and scrub pointer; reset always restarts the scrub from entry 0
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SCRUB;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // scrub walks every entry once, then the file runs until the next reset
    always_comb begin
        ptr_nx   = state == SCRUB ? ptr + 1'b1 : ptr;
        state_nx = (state == SCRUB && ptr == LAST) ? RUN : state;
    end

    // busy and the per-port write acceptance; writes to a hardwired zero entry are discarded
    always_comb begin
        busy  = state == SCRUB;
        wr_ok = ~busy & ~RST;
        acc0  = wr_ok & we0 & ~(ZERO_REG != 0 && wa0 == '0);
        acc1  = wr_ok & we1 & ~(ZERO_REG != 0 && wa1 == '0);
    end

    // storage: scrub clears one entry per cycle; W1 is written last so it wins an address clash
    always_ff @(posedge CLK) begin
        if (!RST && busy) mem[ptr[ADDR_W-1:0]] <= '0;
        if (acc0) mem[wa0] <= wd0;
        if (acc1) mem[wa1] <= wd1;
    end

    // flags a write attempted while the scrub owns the array
    always_ff @(posedge CLK) begin
        if (RST) wr_drop <= 1'b0;
        else     wr_drop <= busy & (we0 | we1);
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        assign a = rd_addr[i*ADDR_W +: ADDR_W];
        // read value, optionally forwarded from an accepted write this cycle (W1 first)
        always_comb begin
`ifdef REGFILE_MP_BYPASS_EN
            v = (acc1 && wa1 == a) ? wd1 : (acc0 && wa0 == a) ? wd0 : mem[a];
`else
            v = mem[a];
`endif
        end
        assign rd_data[i*DATA_W +: DATA_W] = (busy || (ZERO_REG != 0 && a == '0)) ? '0 : v;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven and scoreboard checks for regfile_mp (default parameters)
module tb_regfile_mp;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  wa0 = '0, wa1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        busy, wr_drop;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .CLK(clk), .RST(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    sb_t  sbq[$];
    vec_t vt[8];

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endfunction

    function automatic logic [31:0] obs(int sel);
        return sel == 0 ? rd_data[31:0] : sel == 1 ? rd_data[63:32] :
               sel == 2 ? {31'd0, wr_drop} : {31'd0, busy};
    endfunction

    task automatic push(string n, int sel, logic [31:0] e);
        sbq.push_back('{n, sel, e});
    endtask

    task automatic drain();
        @(negedge clk);
        while (sbq.size() > 0) begin
            sb_t s;
            s = sbq.pop_front();
            chk(s.name, obs(s.sel), s.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(vec_t v);
        we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        rd_addr = {v.ra1, v.ra0};
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic scrub_wait(output int n, output logic drop);
        n = 0;
        drop = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            drop |= wr_drop;
            if (!busy) break;
            n++;
        end
        step();
    endtask

    initial begin
        int   n;
        logic drop;

        vt[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  32'h0,         32'h0};
        vt[1] = '{1'b1, 5'd7,  32'h0000_0001, 1'b1, 5'd7,  32'h0000_0002, 5'd5,  5'd6,  32'hDEAD_BEEF, 32'h0};
        vt[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'hFFFF_FFFF, 5'd7,  5'd5,  32'h0000_0002, 32'hDEAD_BEEF};
        vt[3] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  5'd7,  32'h0,         32'h0000_0002};
        vt[4] = '{1'b1, 5'd10, 32'hAAAA_5555, 1'b1, 5'd11, 32'h1357_9BDF, 5'd0,  5'd31, 32'h0,         32'h0};
        vt[5] = '{1'b1, 5'd31, 32'h8000_0001, 1'b0, 5'd0,  32'h0,         5'd10, 5'd11, 32'hAAAA_5555, 32'h1357_9BDF};
        vt[6] = '{1'b1, 5'd0,  32'h0000_0005, 1'b0, 5'd0,  32'h0,         5'd31, 5'd10, 32'h8000_0001, 32'hAAAA_5555};
        vt[7] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  5'd31, 32'h0,         32'h8000_0001};

        // reset state, reads forced to zero while busy
        rd_addr = {5'd9, 5'd5};
        step();
        push("reset_busy", 3, 32'd1);
        push("reset_wr_drop", 2, 32'd0);
        push("reset_rd0", 0, 32'd0);
        drain();
        step();
        rst = 1'b0;
        scrub_wait(n, drop);
        chk("scrub_len", n, 32'd32);
        chk("scrub_no_drop", {31'd0, drop}, 32'd0);

        // every entry reads zero after the scrub
        for (int k = 0; k < 16; k++) begin
            rd_addr = {5'(2*k+1), 5'(2*k)};
            push($sformatf("scrubbed_%0d", 2*k), 0, 32'd0);
            push($sformatf("scrubbed_%0d", 2*k+1), 1, 32'd0);
            drain();
            step();
        end

        // run-mode vector table: reads see state before this cycle's writes
        for (int k = 0; k < 8; k++) begin
            drive(vt[k]);
            push($sformatf("vec%0d_rd0", k), 0, vt[k].e0);
            push($sformatf("vec%0d_rd1", k), 1, vt[k].e1);
            push($sformatf("vec%0d_wr_drop", k), 2, 32'd0);
            drain();
            step();
        end
        idle();

        // seed entry 3 so the next scrub has something to clear
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h3333_3333;
        step();
        idle();
        rd_addr = {5'd5, 5'd3};
        push("seed_rd3", 0, 32'h3333_3333);
        push("seed_rd5", 1, 32'hDEAD_BEEF);
        drain();
        step();

        // write during scrub cycle 10, reset again at scrub cycle 20
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            we0 = (k == 10);
            wa0 = 5'd3;
            wd0 = 32'hFFFF_0000;
            rst = (k == 20);
            push($sformatf("scrub%0d_busy", k), 3, 32'd1);
            push($sformatf("scrub%0d_wr_drop", k), 2, {31'd0, k == 11});
            push($sformatf("scrub%0d_rd3", k), 0, 32'd0);
            drain();
            step();
        end
        idle();
        rst = 1'b0;
        scrub_wait(n, drop);
        chk("rescrub_len", n, 32'd32);
        chk("rescrub_no_drop", {31'd0, drop}, 32'd0);
        rd_addr = {5'd5, 5'd3};
        push("after_rescrub_rd3", 0, 32'd0);
        push("after_rescrub_rd5", 1, 32'd0);
        drain();
        step();

        // same-cycle read of a write target: bypass or stale value
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_1234;
        rd_addr = {5'd0, 5'd9};
        push("byp_single", 0, BYP ? 32'h0000_1234 : 32'h0);
        drain();
        step();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0001;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0002;
        push("byp_w1_prio", 0, BYP ? 32'h0000_0002 : 32'h0000_1234);
        drain();
        step();
        we0 = 1'b0;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h0000_0007;
        push("byp_rd9", 0, 32'h0000_0002);
        push("byp_zero", 1, 32'h0);
        drain();
        step();
        idle();
        push("post_rd9", 0, 32'h0000_0002);
        push("post_zero", 1, 32'h0);
        push("post_wr_drop", 2, 32'd0);
        drain();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
